// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg : PS/2 frame constants and frame-check helper
// Rev 1.0 : initial release
// ============================================================================
package ps2_pkg;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXTEND     = 8'hE0;

  // Odd parity across the eight data bits plus the parity bit itself.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_keyboard_rx_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with wrap-bit pointers
// Rev 1.0 : initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is taken.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// ps2_keyboard_rx : PS/2 device-to-host frame receiver with scan-code FIFO
// Rev 1.0 : initial release
// ============================================================================
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int         TW   = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST = 4'(PS2_FRAME_BITS - 1);

  logic          clk_s1, clk_s2, clk_s3;
  logic          data_s1, data_s2;
  logic [3:0]    cnt;
  logic [9:0]    buffer;
  logic [TW-1:0] tcnt;

  logic          fall;
  logic          frame_done;
  logic          frame_ok;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;

  assign fall       = clk_s3 & ~clk_s2;
  assign frame_done = fall && (cnt == LAST);
  assign frame_ok   = ~buffer[0] & data_s2 & odd_parity_ok(buffer[9:1]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_s3    <= 1'b1;
      data_s1   <= 1'b1;
      data_s2   <= 1'b1;
      cnt       <= '0;
      tcnt      <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      clk_s3    <= clk_s2;
      data_s1   <= ps2_data;
      data_s2   <= data_s1;
      frame_err <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        if (cnt == LAST) begin
          cnt <= '0;
          if (!frame_ok)
            frame_err <= 1'b1;
          else if (fifo_full && nextdata_n)
            overflow <= 1'b1;
        end else begin
          buffer[cnt] <= data_s2;
          cnt         <= cnt + 4'd1;
        end
      end else if (cnt != 4'd0) begin
        // Keyboard went quiet mid-frame: abandon it and resynchronise.
        if (tcnt == TW'(TIMEOUT - 1)) begin
          cnt       <= '0;
          tcnt      <= '0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (frame_done & frame_ok),
    .pop   (~nextdata_n),
    .wdata (buffer[8:1]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready = ~fifo_empty;
  assign data  = ready ? fifo_rdata : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// tb_ps2_keyboard_rx : queue-based reference model plus directed/random frames
// Rev 1.0 : initial release
// ============================================================================
module tb_ps2_keyboard_rx;

  localparam int DEPTH = 8;
  localparam int TOUT  = 600;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int errcnt = 0;
  bit started = 0;
  bit rnd_en = 0;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  // Reference model: received bits and scan codes kept as queues.
  logic [7:0] q[$];
  bit         bits[$];
  int         idle;
  bit         m_ovf, m_err;
  bit         ck1, ck2, ck3, dt1, dt2;

  always @(posedge clk) begin : model
    bit fall, d, pop, full, ok;
    logic [10:0] fr;
    logic [7:0]  code;
    if (!rst) begin
      q.delete(); bits.delete();
      idle = 0; m_ovf = 0; m_err = 0;
      ck1 = 1; ck2 = 1; ck3 = 1; dt1 = 1; dt2 = 1;
    end else begin
      fall  = ck3 && !ck2;
      d     = dt2;
      m_err = 0;
      pop   = !nextdata_n && (q.size() > 0);
      full  = (q.size() >= DEPTH);
      if (fall) begin
        idle = 0;
        if (bits.size() < 10) begin
          bits.push_back(d);
        end else begin
          for (int i = 0; i < 10; i++) fr[i] = bits[i];
          fr[10] = d;
          for (int i = 0; i < 8; i++) code[i] = fr[i+1];
          ok = (fr[0] == 1'b0) && (fr[10] == 1'b1) && (($countones(fr[9:1]) % 2) == 1);
          if (!ok) m_err = 1;
          else if (!full || pop) q.push_back(code);
          else m_ovf = 1;
          bits.delete();
        end
      end else if (bits.size() != 0) begin
        if (idle == TOUT - 1) begin
          bits.delete(); idle = 0; m_err = 1;
        end else begin
          idle++;
        end
      end else begin
        idle = 0;
      end
      if (pop) void'(q.pop_front());
      ck3 = ck2; ck2 = ck1; ck1 = ps2_clk;
      dt2 = dt1; dt1 = ps2_data;
    end
  end

  task automatic chk1(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk1("ready", ready, q.size() != 0);
      chk8("data", data, (q.size() != 0) ? q[0] : 8'h00);
      chk1("overflow", overflow, m_ovf);
      chk1("frame_err", frame_err, m_err);
      if (frame_err === 1'b1) errcnt++;
    end
  end

  task automatic wait_clk(int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd_en) nextdata_n = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
    end
  endtask

  // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop
  task automatic send_frame(logic [7:0] b, int kind, int nbits, bit pop_at_stop);
    logic [10:0] fr;
    fr[0]   = (kind == 2);
    fr[8:1] = b;
    fr[9]   = ~(^b) ^ (kind == 1);
    fr[10]  = (kind != 3);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        wait_clk(2);
        nextdata_n = 1'b0;
        wait_clk(1);
        nextdata_n = 1'b1;
        wait_clk(HALF - 3);
      end else begin
        wait_clk(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic rd_expect(string name, logic [7:0] exp);
    chk8(name, data, exp);
    nextdata_n = 1'b0;
    wait_clk(1);
    nextdata_n = 1'b1;
    wait_clk(1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int kind, nb;
    wait_clk(3);
    rst = 1'b1;
    started = 1;
    wait_clk(1);
    chk1("rst_ready", ready, 1'b0);
    chk8("rst_data", data, 8'h00);
    chk1("rst_ovf", overflow, 1'b0);
    chk1("rst_err", frame_err, 1'b0);

    // Single good frame
    send_frame(8'h1C, 0, 11, 0);
    chk1("t1_ready", ready, 1'b1);
    rd_expect("t1_data", 8'h1C);
    chk1("t1_empty", ready, 1'b0);
    chk8("t1_data0", data, 8'h00);

    // Parity error
    e0 = errcnt;
    send_frame(8'h1C, 1, 11, 0);
    chk8("t2_errpulses", 8'(errcnt - e0), 8'd1);
    chk1("t2_ready", ready, 1'b0);
    chk1("t2_ovf", overflow, 1'b0);

    // Overflow and ordering
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 11, 0);
    chk1("t3_ovf", overflow, 1'b1);
    for (int i = 1; i <= 8; i++) rd_expect("t3_order", 8'(i));
    chk1("t3_empty", ready, 1'b0);

    // Simultaneous push/pop with a full FIFO
    rst = 1'b0; wait_clk(1); rst = 1'b1; wait_clk(1);
    chk1("t4_ovf_clr", overflow, 1'b0);
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 0, 11, 0);
    send_frame(8'h5A, 0, 11, 1);
    chk1("t4_ovf", overflow, 1'b0);
    for (int i = 1; i < 8; i++) rd_expect("t4_order", 8'h10 + 8'(i));
    rd_expect("t4_last", 8'h5A);
    chk1("t4_empty", ready, 1'b0);

    // Timeout
    e0 = errcnt;
    send_frame(8'h33, 0, 5, 0);
    wait_clk(TOUT + 10);
    chk8("t5_errpulses", 8'(errcnt - e0), 8'd1);
    send_frame(8'h5A, 0, 11, 0);
    rd_expect("t5_data", 8'h5A);

    // Reset mid-frame after an overflow
    for (int i = 0; i < 9; i++) send_frame(8'h20 + 8'(i), 0, 11, 0);
    chk1("t6_ovf_set", overflow, 1'b1);
    send_frame(8'h44, 0, 4, 0);
    rst = 1'b0; wait_clk(1); rst = 1'b1; wait_clk(1);
    chk1("t6_ready", ready, 1'b0);
    chk1("t6_ovf", overflow, 1'b0);
    send_frame(8'hF0, 0, 11, 0);
    rd_expect("t6_data", 8'hF0);

    // Random frames, errors, truncations and reads
    rnd_en = 1;
    for (int n = 0; n < 30; n++) begin
      kind = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      nb   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 10) : 11;
      send_frame(8'($urandom), kind, nb, 0);
      if (nb < 11) wait_clk(TOUT + 5);
    end
    rnd_en = 0;
    nextdata_n = 1'b1;
    wait_clk(1);
    repeat (DEPTH + 1) begin
      if (ready) nextdata_n = 1'b0;
      wait_clk(1);
      nextdata_n = 1'b1;
    end
    wait_clk(1);
    chk1("end_empty", ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
